// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Optional macro BP_STATS_EN adds update / correct-prediction counters.
module branch_predictor #(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] pc_i,
   output logic [31:0] next_pc_o,
   output logic        pred_taken_o,
   output logic [31:0] pred_target_o,
   input  logic        upd_valid_i,
   input  logic [31:0] upd_pc_i,
   input  logic        upd_taken_i,
   input  logic [31:0] upd_target_i
`ifdef BP_STATS_EN
   ,
   output logic [15:0] upd_cnt_o,
   output logic [15:0] correct_cnt_o
`endif
);

   localparam int TAG_W = 30 - IDX_W;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q [ENTRIES];
   logic [31:0]        tgt_q [ENTRIES];
   logic [1:0]         ctr_q [ENTRIES];

   logic [IDX_W-1:0] l_idx;
   logic [TAG_W-1:0] l_tag;
   logic             l_hit;

   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] u_tag;
   logic             u_hit;
   logic [1:0]       u_ctr;
   logic [1:0]       ctr_nxt;

   // Byte offset within the word never participates in index or tag.
   logic unused_lsbs;
   assign unused_lsbs = ^{pc_i[1:0], upd_pc_i[1:0]};

   assign l_idx = pc_i[IDX_W+1:2];
   assign l_tag = pc_i[31:IDX_W+2];
   assign u_idx = upd_pc_i[IDX_W+1:2];
   assign u_tag = upd_pc_i[31:IDX_W+2];

   // Fetch-side lookup reads the registered entry only.
   always_comb begin
      l_hit         = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
      pred_taken_o  = l_hit && ctr_q[l_idx][1];
      pred_target_o = pred_taken_o ? tgt_q[l_idx] : 32'h0;
      next_pc_o     = pred_taken_o ? tgt_q[l_idx] : pc_i + 32'd4;
   end

   // Saturating counter step for the entry being updated.
   always_comb begin
      u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
      u_ctr   = ctr_q[u_idx];
      ctr_nxt = u_ctr;
      if (upd_taken_i) begin
         if (u_ctr != ST) ctr_nxt = u_ctr + 2'd1;
      end else begin
         if (u_ctr != SNT) ctr_nxt = u_ctr - 2'd1;
      end
   end

   // Entry table: reset wins over update, one entry written per edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i] <= '0;
            tgt_q[i] <= '0;
            ctr_q[i] <= WNT;
         end
      end else if (upd_valid_i) begin
         if (u_hit) begin
            ctr_q[u_idx] <= ctr_nxt;
            if (upd_taken_i) tgt_q[u_idx] <= upd_target_i;
         end else if (upd_taken_i) begin
            valid_q[u_idx] <= 1'b1;
            tag_q[u_idx]   <= u_tag;
            tgt_q[u_idx]   <= upd_target_i;
            ctr_q[u_idx]   <= WT;
         end
      end
   end

`ifdef BP_STATS_EN
   logic u_pred;
   assign u_pred = u_hit && u_ctr[1];

   // Saturating statistics, sampled against the pre-update prediction.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         upd_cnt_o     <= '0;
         correct_cnt_o <= '0;
      end else if (upd_valid_i) begin
         if (upd_cnt_o != 16'hFFFF)
            upd_cnt_o <= upd_cnt_o + 16'd1;
         if ((u_pred == upd_taken_i) && (correct_cnt_o != 16'hFFFF))
            correct_cnt_o <= correct_cnt_o + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (scoreboard of lookups).
// Define BP_STATS_EN on both DUT and bench to cover the statistics outputs.
module tb_branch_predictor;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] pc_i;
   logic [31:0] next_pc_o;
   logic        pred_taken_o;
   logic [31:0] pred_target_o;
   logic        upd_valid_i;
   logic [31:0] upd_pc_i;
   logic        upd_taken_i;
   logic [31:0] upd_target_i;
`ifdef BP_STATS_EN
   logic [15:0] upd_cnt_o;
   logic [15:0] correct_cnt_o;
`endif

   branch_predictor #(.ENTRIES(16), .IDX_W(4)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .pc_i          (pc_i),
      .next_pc_o     (next_pc_o),
      .pred_taken_o  (pred_taken_o),
      .pred_target_o (pred_target_o),
      .upd_valid_i   (upd_valid_i),
      .upd_pc_i      (upd_pc_i),
      .upd_taken_i   (upd_taken_i),
      .upd_target_i  (upd_target_i)
`ifdef BP_STATS_EN
      ,
      .upd_cnt_o     (upd_cnt_o),
      .correct_cnt_o (correct_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] pc;
      logic        taken;
      logic [31:0] nxt;
   } exp_t;

   typedef struct {
      logic        do_upd;
      logic [31:0] upc;
      logic        utk;
      logic [31:0] utgt;
      logic [31:0] pc;
      logic        tk;
      logic [31:0] nxt;
   } step_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state
   logic        m_v   [16];
   logic [25:0] m_tag [16];
   logic [31:0] m_tgt [16];
   logic [1:0]  m_ctr [16];
   int          m_upd;
   int          m_cor;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_v[i]   = 1'b0;
         m_tag[i] = '0;
         m_tgt[i] = '0;
         m_ctr[i] = 2'b01;
      end
      m_upd = 0;
      m_cor = 0;
   endtask

   task automatic do_reset();
      rst_i       = 1'b1;
      upd_valid_i = 1'b0;
      tick();
      rst_i = 1'b0;
      model_reset();
   endtask

   task automatic upd(input logic [31:0] p, input logic tk,
                      input logic [31:0] t);
      upd_valid_i  = 1'b1;
      upd_pc_i     = p;
      upd_taken_i  = tk;
      upd_target_i = t;
      tick();
      upd_valid_i  = 1'b0;
   endtask

   task automatic look(input logic [31:0] p, input logic tk,
                       input logic [31:0] n);
      exp_t e;
      pc_i    = p;
      e.pc    = p;
      e.taken = tk;
      e.nxt   = n;
      exp_q.push_back(e);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      logic [31:0] pcs [3];
      pcs[0] = 32'h0040_0000;
      pcs[1] = 32'h0040_0010;
      pcs[2] = 32'hFFFF_FFFC;
      upd_valid_i  = 1'b1;
      upd_pc_i     = 32'h0040_0000;
      upd_taken_i  = 1'b1;
      upd_target_i = 32'h1234_5678;
      rst_i        = 1'b1;
      tick();
      rst_i       = 1'b0;
      upd_valid_i = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         look(pcs[i], 1'b0, pcs[i] + 32'd4);
         e = exp_q.pop_front();
         n_checks++;
         if (pred_taken_o !== e.taken || next_pc_o !== e.nxt ||
             pred_target_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset pc=%h got tk=%b nxt=%h tgt=%h want tk=%b nxt=%h tgt=0",
                     e.pc, pred_taken_o, next_pc_o, pred_target_o,
                     e.taken, e.nxt);
         end
      end
   endtask

   task automatic test_counter();
      exp_t  e;
      step_t s [11];
      logic [31:0] p;
      p = 32'h0040_0010;
      s[0]  = '{1, p, 1, 32'h0040_0100, p, 1, 32'h0040_0100};
      s[1]  = '{1, p, 0, 32'h0,         p, 0, p + 4};
      s[2]  = '{1, p, 0, 32'h0,         p, 0, p + 4};
      s[3]  = '{1, p, 0, 32'h0,         p, 0, p + 4};
      s[4]  = '{1, p, 1, 32'h0040_0200, p, 0, p + 4};
      s[5]  = '{1, p, 1, 32'h0040_0300, p, 1, 32'h0040_0300};
      s[6]  = '{1, p, 1, 32'h0040_0400, p, 1, 32'h0040_0400};
      s[7]  = '{1, p, 1, 32'h0040_0500, p, 1, 32'h0040_0500};
      s[8]  = '{1, p, 0, 32'h0,         p, 1, 32'h0040_0500};
      s[9]  = '{1, p, 0, 32'h0,         p, 0, p + 4};
      s[10] = '{0, p, 1, 32'h0,         p | 32'h3, 0, (p | 32'h3) + 4};
      do_reset();
      for (int i = 0; i < 11; i++) begin
         if (s[i].do_upd) upd(s[i].upc, s[i].utk, s[i].utgt);
         look(s[i].pc, s[i].tk, s[i].nxt);
         e = exp_q.pop_front();
         n_checks++;
         if (pred_taken_o !== e.taken || next_pc_o !== e.nxt ||
             (e.taken && pred_target_o !== e.nxt)) begin
            n_fail++;
            $display("FAIL counter step %0d got tk=%b nxt=%h tgt=%h want tk=%b nxt=%h",
                     i, pred_taken_o, next_pc_o, pred_target_o,
                     e.taken, e.nxt);
         end
      end
   endtask

   task automatic test_alias();
      exp_t  e;
      step_t s [5];
      s[0] = '{1, 32'h0040_0010, 1, 32'h0040_0100,
               32'h0040_0010, 1, 32'h0040_0100};
      s[1] = '{1, 32'h0040_0050, 1, 32'h0040_0800,
               32'h0040_0010, 0, 32'h0040_0014};
      s[2] = '{0, 32'h0, 0, 32'h0,
               32'h0040_0050, 1, 32'h0040_0800};
      s[3] = '{1, 32'h0040_0010, 0, 32'h0,
               32'h0040_0050, 1, 32'h0040_0800};
      s[4] = '{1, 32'h0040_0014, 1, 32'h0040_0900,
               32'h0040_0050, 1, 32'h0040_0800};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         if (s[i].do_upd) upd(s[i].upc, s[i].utk, s[i].utgt);
         look(s[i].pc, s[i].tk, s[i].nxt);
         e = exp_q.pop_front();
         n_checks++;
         if (pred_taken_o !== e.taken || next_pc_o !== e.nxt) begin
            n_fail++;
            $display("FAIL alias step %0d got tk=%b nxt=%h want tk=%b nxt=%h",
                     i, pred_taken_o, next_pc_o, e.taken, e.nxt);
         end
      end
   endtask

   task automatic test_same_cycle();
      exp_t e;
      do_reset();
      upd_valid_i  = 1'b1;
      upd_pc_i     = 32'h0040_0020;
      upd_taken_i  = 1'b1;
      upd_target_i = 32'h0040_0A00;
      for (int i = 0; i < 3; i++) begin
         if (i == 0) look(32'h0040_0020, 1'b0, 32'h0040_0024);
         if (i == 1) begin
            tick();
            upd_valid_i = 1'b0;
            look(32'h0040_0020, 1'b1, 32'h0040_0A00);
         end
         if (i == 2) look(32'hFFFF_FFFC, 1'b0, 32'h0000_0000);
         e = exp_q.pop_front();
         n_checks++;
         if (pred_taken_o !== e.taken || next_pc_o !== e.nxt) begin
            n_fail++;
            $display("FAIL same_cycle step %0d got tk=%b nxt=%h want tk=%b nxt=%h",
                     i, pred_taken_o, next_pc_o, e.taken, e.nxt);
         end
      end
   endtask

   task automatic test_mid_reset();
      exp_t e;
      do_reset();
      for (int i = 0; i < 16; i++)
         upd(32'h0040_0000 + 32'(i * 4), 1'b1, 32'h0080_0000 + 32'(i));
      upd_valid_i  = 1'b1;
      upd_pc_i     = 32'h0040_0008;
      upd_taken_i  = 1'b1;
      upd_target_i = 32'h0090_0000;
      rst_i        = 1'b1;
      tick();
      rst_i       = 1'b0;
      upd_valid_i = 1'b0;
      model_reset();
      for (int i = 0; i < 16; i++) begin
         look(32'h0040_0000 + 32'(i * 4), 1'b0,
              32'h0040_0004 + 32'(i * 4));
         e = exp_q.pop_front();
         n_checks++;
         if (pred_taken_o !== e.taken || next_pc_o !== e.nxt) begin
            n_fail++;
            $display("FAIL mid_reset idx %0d got tk=%b nxt=%h want tk=%b nxt=%h",
                     i, pred_taken_o, next_pc_o, e.taken, e.nxt);
         end
      end
      upd(32'h0040_0004, 1'b0, 32'h0);
      look(32'h0040_0004, 1'b0, 32'h0040_0008);
      e = exp_q.pop_front();
      n_checks++;
      if (pred_taken_o !== e.taken || next_pc_o !== e.nxt) begin
         n_fail++;
         $display("FAIL mid_reset_nt_miss got tk=%b nxt=%h want tk=%b nxt=%h",
                  pred_taken_o, next_pc_o, e.taken, e.nxt);
      end
   endtask

   task automatic test_random();
      exp_t        e;
      logic [31:0] p, up, ut;
      logic        uv, tk, hit, pred;
      int          li, ui;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         p  = {($urandom_range(0, 1) != 0) ? 26'h001_0000 : 26'h001_0001,
               4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
         up = {($urandom_range(0, 1) != 0) ? 26'h001_0000 : 26'h001_0001,
               4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
         uv = ($urandom_range(0, 3) != 0);
         tk = ($urandom_range(0, 2) != 0);
         ut = $urandom;
         li = int'(p[5:2]);
         hit  = m_v[li] && (m_tag[li] == p[31:6]);
         pred = hit && m_ctr[li][1];
         upd_valid_i  = uv;
         upd_pc_i     = up;
         upd_taken_i  = tk;
         upd_target_i = ut;
         look(p, pred, pred ? m_tgt[li] : p + 32'd4);
         e = exp_q.pop_front();
         n_checks++;
         if (pred_taken_o !== e.taken || next_pc_o !== e.nxt) begin
            n_fail++;
            $display("FAIL random cyc %0d pc=%h got tk=%b nxt=%h want tk=%b nxt=%h",
                     n, e.pc, pred_taken_o, next_pc_o, e.taken, e.nxt);
         end
         tick();
         if (uv) begin
            ui  = int'(up[5:2]);
            hit = m_v[ui] && (m_tag[ui] == up[31:6]);
            if (m_upd < 65535) m_upd++;
            if ((hit && m_ctr[ui][1]) == tk && m_cor < 65535) m_cor++;
            if (hit) begin
               if (tk) begin
                  if (m_ctr[ui] != 2'b11) m_ctr[ui] = m_ctr[ui] + 2'd1;
                  m_tgt[ui] = ut;
               end else if (m_ctr[ui] != 2'b00) begin
                  m_ctr[ui] = m_ctr[ui] - 2'd1;
               end
            end else if (tk) begin
               m_v[ui]   = 1'b1;
               m_tag[ui] = up[31:6];
               m_tgt[ui] = ut;
               m_ctr[ui] = 2'b10;
            end
         end
      end
      upd_valid_i = 1'b0;
`ifdef BP_STATS_EN
      n_checks++;
      if (upd_cnt_o !== 16'(m_upd) || correct_cnt_o !== 16'(m_cor)) begin
         n_fail++;
         $display("FAIL random_stats got upd=%0d cor=%0d want upd=%0d cor=%0d",
                  upd_cnt_o, correct_cnt_o, m_upd, m_cor);
      end
`endif
   endtask

`ifdef BP_STATS_EN
   task automatic test_stats();
      exp_t e;
      do_reset();
      n_checks++;
      if (upd_cnt_o !== 16'd0 || correct_cnt_o !== 16'd0) begin
         n_fail++;
         $display("FAIL stats_reset got upd=%0d cor=%0d want 0 0",
                  upd_cnt_o, correct_cnt_o);
      end
      upd(32'h0040_0030, 1'b0, 32'h0);
      upd(32'h0040_0010, 1'b1, 32'h0040_0100);
      upd(32'h0040_0010, 1'b1, 32'h0040_0100);
      n_checks++;
      if (upd_cnt_o !== 16'd3 || correct_cnt_o !== 16'd2) begin
         n_fail++;
         $display("FAIL stats_count got upd=%0d cor=%0d want 3 2",
                  upd_cnt_o, correct_cnt_o);
      end
      upd_valid_i  = 1'b1;
      upd_pc_i     = 32'h0040_0010;
      upd_taken_i  = 1'b1;
      upd_target_i = 32'h0040_0100;
      rst_i        = 1'b1;
      tick();
      rst_i       = 1'b0;
      upd_valid_i = 1'b0;
      model_reset();
      look(32'h0040_0010, 1'b0, 32'h0040_0014);
      e = exp_q.pop_front();
      n_checks++;
      if (upd_cnt_o !== 16'd0 || correct_cnt_o !== 16'd0 ||
          pred_taken_o !== e.taken || next_pc_o !== e.nxt) begin
         n_fail++;
         $display("FAIL stats_mid_reset got upd=%0d cor=%0d tk=%b nxt=%h want 0 0 tk=%b nxt=%h",
                  upd_cnt_o, correct_cnt_o, pred_taken_o, next_pc_o,
                  e.taken, e.nxt);
      end
   endtask
`endif

   initial begin
      rst_i        = 1'b1;
      pc_i         = 32'h0040_0000;
      upd_valid_i  = 1'b0;
      upd_pc_i     = '0;
      upd_taken_i  = 1'b0;
      upd_target_i = '0;
      model_reset();
      #1;
      test_reset();
      test_counter();
      test_alias();
      test_same_cycle();
      test_mid_reset();
      test_random();
`ifdef BP_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
